// File: rtl/verificador_sequencia.sv
// Sequence checker for the self-starting counter: measures settle time,
// declares lock after a run of correct transitions, then flags every
// wrong transition or illegal value while locked.
module verificador_sequencia #(
  parameter int unsigned FIRST      = 0,
  parameter int unsigned LAST       = 9,
  parameter int unsigned LOCK_RUN   = 4,
  parameter int unsigned MAX_SETTLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  output logic       locked,
  output logic       err,
  output logic       illegal,
  output logic       timeout,
  output logic [7:0] err_cnt,
  output logic [7:0] cycles_to_lock
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 8;
  localparam int unsigned SPAN   = LAST - FIRST;

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    prev_q, prev_d;
  logic [CNT_W-1:0]    run_q, run_d;
  logic [STAT_W-1:0]   settle_q, settle_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;
  logic [STAT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [STAT_W-1:0]   ctl_q, ctl_d;
  logic                lock_seen_q, lock_seen_d;

  logic [CNT_W:0]      offset_c;
  logic                legal_c;
  logic [CNT_W-1:0]    expected_c;
  logic                match_c;
  logic                run_done_c;

  // Legality via offset from FIRST: values below FIRST wrap to a large offset.
  always_comb begin
    offset_c   = {1'b0, count} - (CNT_W+1)'(FIRST);
    legal_c    = (offset_c <= (CNT_W+1)'(SPAN));
    expected_c = (prev_q == CNT_W'(LAST)) ? CNT_W'(FIRST) : prev_q + CNT_W'(1);
    match_c    = (count == expected_c);
    run_done_c = (({1'b0, run_q} + (CNT_W+1)'(1)) == (CNT_W+1)'(LOCK_RUN));
  end

  // Next-state and next-output logic for the checker FSM and its statistics.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    run_d       = run_q;
    settle_d    = settle_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    illegal_d   = 1'b0;
    err_cnt_d   = err_cnt_q;
    ctl_d       = ctl_q;
    timeout_d   = timeout_q;
    lock_seen_d = lock_seen_q;

    case (state_q)
      ST_SETTLE: begin
        if (legal_c) begin
          prev_d  = count;
          run_d   = '0;
          state_d = ST_ACQUIRE;
        end else if (settle_q != '1) begin
          settle_d = settle_q + STAT_W'(1);
        end
      end

      ST_ACQUIRE: begin
        if (!legal_c) begin
          // settle_cnt deliberately carries over so repeated drop-outs accumulate
          state_d = ST_SETTLE;
        end else if (match_c) begin
          prev_d = count;
          if (run_done_c) begin
            run_d    = '0;
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
          end else begin
            run_d = run_q + CNT_W'(1);
          end
        end else begin
          prev_d = count;
          run_d  = '0;
        end
      end

      ST_LOCKED: begin
        if (match_c) begin
          prev_d = count;
        end else begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + STAT_W'(1);
          end
          if (legal_c) begin
            prev_d  = count;
            run_d   = '0;
            state_d = ST_ACQUIRE;
          end else begin
            illegal_d = 1'b1;
            state_d   = ST_SETTLE;
          end
        end
      end

      default: begin
        state_d  = ST_SETTLE;
        locked_d = 1'b0;
        run_d    = '0;
      end
    endcase

    // Sticky timeout; checking continues regardless.
    if (settle_d >= STAT_W'(MAX_SETTLE)) begin
      timeout_d = 1'b1;
    end

    // Lock latency counts every edge up to and including the first lock edge.
    if (!lock_seen_q) begin
      if (ctl_q != '1) begin
        ctl_d = ctl_q + STAT_W'(1);
      end
      lock_seen_d = locked_d;
    end
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SETTLE;
      prev_q      <= '0;
      run_q       <= '0;
      settle_q    <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= '0;
      ctl_q       <= '0;
      lock_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      settle_q    <= settle_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
      err_cnt_q   <= err_cnt_d;
      ctl_q       <= ctl_d;
      lock_seen_q <= lock_seen_d;
    end
  end

  assign locked         = locked_q;
  assign err            = err_q;
  assign illegal        = illegal_q;
  assign timeout        = timeout_q;
  assign err_cnt        = err_cnt_q;
  assign cycles_to_lock = ctl_q;

endmodule

// File: doc/verificador_sequencia.md
# verificador_sequencia

Synchronous sequence checker that observes the 4-bit output of the team's self-starting sequential counter and checks it every clock. It measures how long the counter takes to reach a legal state after reset, declares lock after a run of correct transitions, and then flags every illegal state or wrong transition. It sits beside the counter in simulation and in silicon as a built-in health monitor, on the counter's clock and reset.

## Interface
- FIRST, 0: first value of the legal sequence.
- LAST, 9: last legal value; the counter wraps from LAST to FIRST. Requires 0 <= FIRST < LAST <= 15.
- LOCK_RUN, 4: number of consecutive correct transitions required for lock (1..15).
- MAX_SETTLE, 16: maximum number of illegal samples tolerated before timeout (1..255).
- clk  in  1  rising-edge clock shared with the counter.
- reset  in  1  synchronous, active-high reset.
- count  in  4  counter output, sampled on every rising edge of clk.
- locked  out  1  high while the sequence is locked.
- err  out  1  one-cycle pulse on a mismatch while locked.
- illegal  out  1  one-cycle pulse when a locked mismatch lands on an illegal value.
- timeout  out  1  sticky; the settle limit was exceeded.
- err_cnt  out  8  number of err pulses, saturating at 255.
- cycles_to_lock  out  8  edges from reset release to first lock, saturating at 255.

## Operation
- Legal value: FIRST <= count <= LAST. Expected next value: FIRST if prev == LAST, otherwise prev+1.
- FSM states are SETTLE, ACQUIRE and LOCKED. Reset enters SETTLE.
- **SETTLE**
  - Illegal sample: settle_cnt increments, saturating at 255.
  - When settle_cnt reaches MAX_SETTLE, timeout sets.
  - Legal sample: prev <= count, run <= 0, next state ACQUIRE.
- **ACQUIRE**
  - Sample == expected: prev <= count, run increments.
  - If run+1 == LOCK_RUN: next state LOCKED and locked <= 1.
  - Legal mismatch: prev <= count, run <= 0, stay in ACQUIRE, no err.
  - Illegal sample: next state SETTLE; settle_cnt keeps its value and is not cleared.
- **LOCKED**
  - Sample == expected: prev <= count.
  - Mismatch: err pulse, err_cnt increments (saturating), locked <= 0.
  - Legal mismatch: next state ACQUIRE with prev <= count, run <= 0.
  - Illegal mismatch: illegal pulse too, next state SETTLE.
- cycles_to_lock:
  - Increments every edge after reset until locked first rises, saturating at 255.
  - Freezes at the first lock and holds until reset; later relocks do not change it.
- timeout does not stop checking; lock can still be reached afterwards.
- err and illegal never assert outside LOCKED.

## Timing
- All outputs are registered. A response appears in the cycle after the edge that sampled the triggering count.
- Reset is synchronous. It must be high across at least one rising edge, and it has priority over every other event.
- Reset values: locked=0, err=0, illegal=0, timeout=0, err_cnt=0, cycles_to_lock=0, run=0, settle_cnt=0, state SETTLE.
- Reset mid-operation clears everything on that edge. The first sample after reset falls is on the next edge.
- Lock latency from the first legal sample: LOCK_RUN further correct edges. locked is high in the cycle after the LOCK_RUN-th correct sample.
- Wrap (LAST -> FIRST) is a correct transition and must not produce err.
- A count held constant for one edge is a mismatch.
- On the edge where err_cnt is 255, err still pulses and err_cnt stays at 255.

## Test plan
- Reset, then drive count 0,1,2,...,9,0,1 → locked rises after the 5th sample (0..4); cycles_to_lock=5; err never asserts across the 9→0 wrap.
- Reset, then drive count 12,13,14,3,4,5,6,7 → settle_cnt=3, no timeout; locked rises after 7 is sampled.
- Reset, then hold count=15 for 20 edges → timeout rises after the 16th sample; locked stays 0, err stays 0.
- Locked at 5, then drive 7 → single err pulse, illegal=0, locked=0, err_cnt=1; then 8,9,0,1 → relocks; cycles_to_lock is unchanged.
- Locked, then drive 11 → err and illegal pulse together, state SETTLE; then 300 further injected mismatches with relocks between them → err_cnt saturates at 255.
- Locked, then assert reset for one edge mid-sequence → every output is 0 on the next cycle; the lock sequence repeats with cycles_to_lock recounted from 0.
